// File: rtl/mips_mem_responder_if.sv
// Memory port between the multicycle MIPS core and its memory responder.
// The core drives the master side and the responder drives the slave side.
interface mips_mem_responder_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        memread;
  logic [31:0] readdata;
  logic        ready;
  logic        fault;
  logic        done;
  logic        pass;

  modport master (
    output adr, writedata, memwrite, memread,
    input  readdata, ready, fault, done, pass
  );

  modport slave (
    input  adr, writedata, memwrite, memread,
    output readdata, ready, fault, done, pass
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Word-addressed RAM responder with configurable wait states that also
// watches committed stores and latches a sticky program pass/fail verdict.
module mips_mem_responder #(
  parameter int          DEPTH_LOG2  = 6,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] WATCH_ADR   = 32'd84,
  parameter logic [31:0] WATCH_DATA  = 32'd7,
  parameter logic [31:0] IGNORE_ADR  = 32'd80
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mem_responder_if.slave  bus
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wrData_q, wrData_d;
  logic        isWrite_q, isWrite_d;
  logic [31:0] readdata_q, readdata_d;
  logic        fault_q, fault_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        memWe;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] idx_d;
  logic                  aligned_q;

  assign idx_q     = adr_q[DEPTH_LOG2+1:2];
  assign idx_d     = adr_d[DEPTH_LOG2+1:2];
  assign aligned_q = (adr_q[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      adr_q      <= 32'd0;
      wrData_q   <= 32'd0;
      isWrite_q  <= 1'b0;
      readdata_q <= 32'd0;
      fault_q    <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      adr_q      <= adr_d;
      wrData_q   <= wrData_d;
      isWrite_q  <= isWrite_d;
      readdata_q <= readdata_d;
      fault_q    <= fault_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  // RAM is deliberately not reset; a reset in RESP must still block the commit.
  always_ff @(posedge clk) begin
    if (memWe && !reset) begin
      mem[idx_q] <= wrData_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    adr_d      = adr_q;
    wrData_d   = wrData_q;
    isWrite_d  = isWrite_q;
    readdata_d = 32'd0;
    fault_d    = fault_q;
    done_d     = done_q;
    pass_d     = pass_q;
    memWe      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.memwrite || bus.memread) begin
          adr_d     = bus.adr;
          wrData_d  = bus.writedata;
          isWrite_d = bus.memwrite;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d   = WAIT;
            waitCnt_d = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d   = IDLE;
        waitCnt_d = 4'd0;
        if (!aligned_q) begin
          fault_d = 1'b1;
        end else if (isWrite_q) begin
          memWe = 1'b1;
          if (!done_q) begin
            if (adr_q == WATCH_ADR && wrData_q == WATCH_DATA) begin
              done_d = 1'b1;
              pass_d = 1'b1;
            end else if (adr_q != IGNORE_ADR) begin
              done_d = 1'b1;
              pass_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read data is captured on the edge that enters RESP so it lines up with ready.
    if (state_q != RESP && state_d == RESP && !isWrite_d && adr_d[1:0] == 2'b00) begin
      readdata_d = mem[idx_d];
    end
  end

  assign bus.ready    = (state_q == RESP);
  assign bus.readdata = readdata_q;
  assign bus.fault    = fault_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed vector table, reset
// abort sequence, zero-wait build latency, and random traffic vs a model.
module tb_mips_mem_responder;

  localparam int WAIT_MAIN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mips_mem_responder_if busMain ();
  mips_mem_responder_if busZero ();

  mips_mem_responder #(.WAIT_CYCLES(WAIT_MAIN)) dutMain (
    .clk   (clk),
    .reset (reset),
    .bus   (busMain)
  );

  mips_mem_responder #(.WAIT_CYCLES(0)) dutZero (
    .clk   (clk),
    .reset (reset),
    .bus   (busZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] expRd;
    bit          expFault;
    bit          expDone;
    bit          expPass;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] mdl [64];
  bit          known [64];
  bit          mFault, mDone, mPass;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    busMain.memwrite = 1'b0;
    busMain.memread  = 1'b0;
    busZero.memwrite = 1'b0;
    busZero.memread  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issues one request, waits (bounded) for ready, then samples one cycle later.
  task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output int lat, output logic readyAfter);
    busMain.adr       = a;
    busMain.writedata = d;
    busMain.memwrite  = wr;
    busMain.memread   = !wr;
    lat = 0;
    rd  = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busMain.ready) begin
        lat = i;
        rd  = busMain.readdata;
        break;
      end
    end
    busMain.memwrite = 1'b0;
    busMain.memread  = 1'b0;
    @(posedge clk);
    #1;
    readyAfter = busMain.ready;
  endtask

  function automatic void modelAccess(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                      output logic [31:0] expRd, output bit rdKnown);
    int idx;
    idx     = int'((a / 4) % 64);
    expRd   = 32'd0;
    rdKnown = 1'b0;
    if ((a % 4) != 0) begin
      mFault  = 1'b1;
      rdKnown = !wr;
    end else if (wr) begin
      mdl[idx]   = d;
      known[idx] = 1'b1;
      if (!mDone) begin
        if (a == 32'd84 && d == 32'd7) begin
          mDone = 1'b1;
          mPass = 1'b1;
        end else if (a != 32'd80) begin
          mDone = 1'b1;
          mPass = 1'b0;
        end
      end
    end else begin
      expRd   = mdl[idx];
      rdKnown = known[idx];
    end
  endfunction

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        readyAfter;
    logic [31:0] expRd;
    bit          rdKnown;

    vecs.push_back('{1'b1, 1'b1, 32'd80,  32'd5,          32'd0,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd80,  32'd7,          32'd0,          1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd84,  32'd7,          32'd0,          1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'd60,  32'd9,          32'd0,          1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'd60,  32'd0,          32'd9,          1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'd8,   32'h12345678,   32'd0,          1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'd8,   32'd0,          32'h12345678,   1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'd260, 32'hA5,         32'd0,          1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'd4,   32'd0,          32'hA5,         1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'd88,  32'd7,          32'd0,          1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd84,  32'd7,          32'd0,          1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'd88,  32'd0,          32'd7,          1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'd6,   32'd0,          32'd0,          1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd6,   32'hDEAD,       32'd0,          1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'd4,   32'd0,          32'hA5,         1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd84,  32'd7,          32'd0,          1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'd84,  32'd8,          32'd0,          1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'd84,  32'd0,          32'd8,          1'b0, 1'b0, 1'b0});

    busMain.adr = 32'd0; busMain.writedata = 32'd0;
    busMain.memwrite = 1'b0; busMain.memread = 1'b0;
    busZero.adr = 32'd0; busZero.writedata = 32'd0;
    busZero.memwrite = 1'b0; busZero.memread = 1'b0;

    doReset();
    checkOutput("reset.ready",    32'(busMain.ready),    32'd0);
    checkOutput("reset.readdata", busMain.readdata,      32'd0);
    checkOutput("reset.fault",    32'(busMain.fault),    32'd0);
    checkOutput("reset.done",     32'(busMain.done),     32'd0);
    checkOutput("reset.pass",     32'(busMain.pass),     32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].wr, vecs[i].adr, vecs[i].data, rd, lat, readyAfter);
      checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'(WAIT_MAIN + 1));
      checkOutput($sformatf("vec%0d.readyWidth", i), 32'(readyAfter), 32'd0);
      if (!vecs[i].wr) checkOutput($sformatf("vec%0d.readdata", i), rd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d.fault", i), 32'(busMain.fault), 32'(vecs[i].expFault));
      checkOutput($sformatf("vec%0d.done", i),  32'(busMain.done),  32'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d.pass", i),  32'(busMain.pass),  32'(vecs[i].expPass));
    end

    // Reset asserted while a write to word 3 sits in WAIT.
    doReset();
    applyStimulus(1'b1, 32'd12, 32'h0C0C0C0C, rd, lat, readyAfter);
    checkOutput("abort.preDone", 32'(busMain.done), 32'd1);
    busMain.adr = 32'd12; busMain.writedata = 32'h00000BAD; busMain.memwrite = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort.readyInWait", 32'(busMain.ready), 32'd0);
    reset = 1'b1; busMain.memwrite = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort.readyInReset", 32'(busMain.ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort.ready", 32'(busMain.ready), 32'd0);
    checkOutput("abort.done",  32'(busMain.done),  32'd0);
    checkOutput("abort.pass",  32'(busMain.pass),  32'd0);
    checkOutput("abort.fault", 32'(busMain.fault), 32'd0);
    applyStimulus(1'b0, 32'd12, 32'd0, rd, lat, readyAfter);
    checkOutput("abort.readLatency", 32'(lat), 32'(WAIT_MAIN + 1));
    checkOutput("abort.ram3", rd, 32'h0C0C0C0C);

    // Zero-wait build: ready one cycle after the request edge.
    busZero.adr = 32'd16; busZero.writedata = 32'hCAFE; busZero.memwrite = 1'b1;
    @(posedge clk); #1;
    checkOutput("zero.writeReady", 32'(busZero.ready), 32'd1);
    busZero.memwrite = 1'b0;
    @(posedge clk); #1;
    checkOutput("zero.readyWidth", 32'(busZero.ready), 32'd0);
    checkOutput("zero.done", 32'(busZero.done), 32'd1);
    busZero.memread = 1'b1;
    @(posedge clk); #1;
    checkOutput("zero.readReady", 32'(busZero.ready), 32'd1);
    checkOutput("zero.readdata", busZero.readdata, 32'hCAFE);
    busZero.memread = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the behavioural model.
    doReset();
    mFault = 1'b0; mDone = 1'b0; mPass = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mdl[i] = 32'd0;
      known[i] = 1'b0;
    end
    for (int n = 0; n < 80; n++) begin
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      int          sel;
      if (n % 20 == 19) begin
        doReset();
        mFault = 1'b0; mDone = 1'b0; mPass = 1'b0;
      end
      wr  = bit'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 32'd84;
      else if (sel == 1) a = 32'd80;
      else if (sel == 2) a = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
      else               a = 32'($urandom_range(0, 127)) * 4;
      d = ($urandom_range(0, 3) == 0) ? 32'd7 : 32'($urandom);
      modelAccess(wr, a, d, expRd, rdKnown);
      applyStimulus(wr, a, d, rd, lat, readyAfter);
      checkOutput($sformatf("rnd%0d.latency", n), 32'(lat), 32'(WAIT_MAIN + 1));
      if (rdKnown) checkOutput($sformatf("rnd%0d.readdata", n), rd, expRd);
      checkOutput($sformatf("rnd%0d.fault", n), 32'(busMain.fault), 32'(mFault));
      checkOutput($sformatf("rnd%0d.done", n),  32'(busMain.done),  32'(mDone));
      checkOutput($sformatf("rnd%0d.pass", n),  32'(busMain.pass),  32'(mPass));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
